// File: rtl/sram_pkg.sv
// rtl/sram_pkg.sv - shared SRAM constants and arbiter state type
package sram_pkg;

    localparam int SRAM_AW = 15;
    localparam int SRAM_DW = 8;

    // Port select encoding used for grant_sel / last_grant
    localparam logic SEL_A = 1'b0;
    localparam logic SEL_B = 1'b1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } arb_state_t;

endpackage

// File: rtl/sram_rr_pick.sv
// rtl/sram_rr_pick.sv - combinational two-way round-robin picker
module sram_rr_pick
    import sram_pkg::*;
(
    input  logic a_req,
    input  logic b_req,
    input  logic last_grant,
    output logic grant_valid,
    output logic grant_sel
);

    // Lone requester wins outright; on a tie the port not served last wins
    always_comb begin
        grant_valid = a_req | b_req;
        grant_sel   = SEL_A;
        if (a_req && b_req) begin
            grant_sel = ~last_grant;
        end else if (b_req) begin
            grant_sel = SEL_B;
        end
    end

endmodule

// File: rtl/sram_arbiter.sv
// rtl/sram_arbiter.sv - two-port round-robin arbiter in front of the SRAM controller
module sram_arbiter
    import sram_pkg::*;
#(
    parameter int ACC_CYCLES = 4,
    parameter int AW         = SRAM_AW,
    parameter int DW         = SRAM_DW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          a_req,
    input  logic          a_we,
    input  logic [AW-1:0] a_addr,
    input  logic [DW-1:0] a_wdata,
    output logic          a_ack,
    output logic          a_rvalid,
    output logic [DW-1:0] a_rdata,
    input  logic          b_req,
    input  logic          b_we,
    input  logic [AW-1:0] b_addr,
    input  logic [DW-1:0] b_wdata,
    output logic          b_ack,
    output logic          b_rvalid,
    output logic [DW-1:0] b_rdata,
    output logic          busy,
    output logic          sram_wreq,
    output logic [AW-1:0] sram_waddr,
    output logic [DW-1:0] sram_wdata,
    output logic          sram_rreq,
    output logic [AW-1:0] sram_raddr,
    input  logic [DW-1:0] sram_rdata
);

    // Counter is loaded in ISSUE so the last WAIT cycle is ACC_CYCLES after the request pulse
    localparam logic [3:0] CNT_LOAD = 4'(ACC_CYCLES - 1);

    arb_state_t    state_q, state_d;
    logic          sel_q, sel_d;
    logic          we_q, we_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [DW-1:0] wdata_q, wdata_d;
    logic [3:0]    cnt_q, cnt_d;
    logic          last_grant_q, last_grant_d;
    logic          a_ack_q, a_ack_d;
    logic          b_ack_q, b_ack_d;
    logic          a_rvalid_q, a_rvalid_d;
    logic          b_rvalid_q, b_rvalid_d;
    logic [DW-1:0] a_rdata_q, a_rdata_d;
    logic [DW-1:0] b_rdata_q, b_rdata_d;
    logic          busy_q, busy_d;
    logic          wreq_q, wreq_d;
    logic          rreq_q, rreq_d;

    logic          grant_valid;
    logic          grant_sel;

    sram_rr_pick u_pick (
        .a_req       (a_req),
        .b_req       (b_req),
        .last_grant  (last_grant_q),
        .grant_valid (grant_valid),
        .grant_sel   (grant_sel)
    );

    // Next-state and registered-output computation; pulses are set on entry to their state
    always_comb begin
        state_d      = state_q;
        sel_d        = sel_q;
        we_d         = we_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        cnt_d        = cnt_q;
        last_grant_d = last_grant_q;
        a_ack_d      = 1'b0;
        b_ack_d      = 1'b0;
        a_rvalid_d   = 1'b0;
        b_rvalid_d   = 1'b0;
        a_rdata_d    = a_rdata_q;
        b_rdata_d    = b_rdata_q;
        wreq_d       = 1'b0;
        rreq_d       = 1'b0;

        case (state_q)
            IDLE: begin
                if (grant_valid) begin
                    sel_d   = grant_sel;
                    we_d    = (grant_sel == SEL_B) ? b_we    : a_we;
                    addr_d  = (grant_sel == SEL_B) ? b_addr  : a_addr;
                    wdata_d = (grant_sel == SEL_B) ? b_wdata : a_wdata;
                    wreq_d  = we_d;
                    rreq_d  = ~we_d;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                cnt_d   = CNT_LOAD;
                state_d = WAIT;
            end
            WAIT: begin
                if (cnt_q == 4'd0) begin
                    if (sel_q == SEL_B) begin
                        b_ack_d    = 1'b1;
                        b_rvalid_d = ~we_q;
                        if (!we_q) b_rdata_d = sram_rdata;
                    end else begin
                        a_ack_d    = 1'b1;
                        a_rvalid_d = ~we_q;
                        if (!we_q) a_rdata_d = sram_rdata;
                    end
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            DONE: begin
                last_grant_d = sel_q;
                state_d      = IDLE;
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);
    end

    // State and output registers; reset aborts any access in flight
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            sel_q        <= SEL_A;
            we_q         <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            cnt_q        <= 4'd0;
            last_grant_q <= SEL_B;
            a_ack_q      <= 1'b0;
            b_ack_q      <= 1'b0;
            a_rvalid_q   <= 1'b0;
            b_rvalid_q   <= 1'b0;
            a_rdata_q    <= '0;
            b_rdata_q    <= '0;
            busy_q       <= 1'b0;
            wreq_q       <= 1'b0;
            rreq_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            sel_q        <= sel_d;
            we_q         <= we_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            cnt_q        <= cnt_d;
            last_grant_q <= last_grant_d;
            a_ack_q      <= a_ack_d;
            b_ack_q      <= b_ack_d;
            a_rvalid_q   <= a_rvalid_d;
            b_rvalid_q   <= b_rvalid_d;
            a_rdata_q    <= a_rdata_d;
            b_rdata_q    <= b_rdata_d;
            busy_q       <= busy_d;
            wreq_q       <= wreq_d;
            rreq_q       <= rreq_d;
        end
    end

    assign a_ack      = a_ack_q;
    assign b_ack      = b_ack_q;
    assign a_rvalid   = a_rvalid_q;
    assign b_rvalid   = b_rvalid_q;
    assign a_rdata    = a_rdata_q;
    assign b_rdata    = b_rdata_q;
    assign busy       = busy_q;
    assign sram_wreq  = wreq_q;
    assign sram_rreq  = rreq_q;
    assign sram_waddr = addr_q;
    assign sram_raddr = addr_q;
    assign sram_wdata = wdata_q;

endmodule

// File: tb/tb_sram_arbiter.sv
// tb/tb_sram_arbiter.sv - directed self-checking bench for sram_arbiter
module tb_sram_arbiter;

    localparam int ACC = 4;
    localparam int AW  = 15;
    localparam int DW  = 8;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic          a_req, a_we, a_ack, a_rvalid;
    logic [AW-1:0] a_addr;
    logic [DW-1:0] a_wdata, a_rdata;
    logic          b_req, b_we, b_ack, b_rvalid;
    logic [AW-1:0] b_addr;
    logic [DW-1:0] b_wdata, b_rdata;
    logic          busy, sram_wreq, sram_rreq;
    logic [AW-1:0] sram_waddr, sram_raddr;
    logic [DW-1:0] sram_wdata, sram_rdata;

    logic          s_a_req, s_a_we, s_a_ack, s_a_rvalid;
    logic [AW-1:0] s_a_addr;
    logic [DW-1:0] s_a_wdata, s_a_rdata;
    logic          s_b_req, s_b_we, s_b_ack, s_b_rvalid;
    logic [AW-1:0] s_b_addr;
    logic [DW-1:0] s_b_wdata, s_b_rdata;
    logic          s_busy, s_sram_wreq, s_sram_rreq;
    logic [AW-1:0] s_sram_waddr, s_sram_raddr;
    logic [DW-1:0] s_sram_wdata, s_sram_rdata;

    sram_arbiter #(.ACC_CYCLES(ACC), .AW(AW), .DW(DW)) u_dut (
        .clk(clk), .rst(rst),
        .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
        .a_ack(a_ack), .a_rvalid(a_rvalid), .a_rdata(a_rdata),
        .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
        .b_ack(b_ack), .b_rvalid(b_rvalid), .b_rdata(b_rdata),
        .busy(busy),
        .sram_wreq(sram_wreq), .sram_waddr(sram_waddr), .sram_wdata(sram_wdata),
        .sram_rreq(sram_rreq), .sram_raddr(sram_raddr), .sram_rdata(sram_rdata)
    );

    sram_arbiter #(.ACC_CYCLES(1), .AW(AW), .DW(DW)) u_dut1 (
        .clk(clk), .rst(rst),
        .a_req(s_a_req), .a_we(s_a_we), .a_addr(s_a_addr), .a_wdata(s_a_wdata),
        .a_ack(s_a_ack), .a_rvalid(s_a_rvalid), .a_rdata(s_a_rdata),
        .b_req(s_b_req), .b_we(s_b_we), .b_addr(s_b_addr), .b_wdata(s_b_wdata),
        .b_ack(s_b_ack), .b_rvalid(s_b_rvalid), .b_rdata(s_b_rdata),
        .busy(s_busy),
        .sram_wreq(s_sram_wreq), .sram_waddr(s_sram_waddr), .sram_wdata(s_sram_wdata),
        .sram_rreq(s_sram_rreq), .sram_raddr(s_sram_raddr), .sram_rdata(s_sram_rdata)
    );

    typedef struct {
        logic          use_b;
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [DW-1:0] rdval;
    } vec_t;

    vec_t          vecs[6];
    int            n_tests = 0;
    int            n_fail  = 0;
    logic [DW-1:0] exp_a_rdata = '0;
    logic [DW-1:0] exp_b_rdata = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b0;
        a_req = 1'b0; b_req = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        exp_a_rdata = '0;
        exp_b_rdata = '0;
        @(posedge clk); #1;
    endtask

    task automatic run_txn(input vec_t v);
        if (v.use_b) begin
            b_we = v.we; b_addr = v.addr; b_wdata = v.wdata; b_req = 1'b1;
        end else begin
            a_we = v.we; a_addr = v.addr; a_wdata = v.wdata; a_req = 1'b1;
        end
        for (int n = 1; n <= ACC + 3; n++) begin
            @(posedge clk); #1;
            if (n == 1) begin
                chk("issue_wreq", 32'(sram_wreq), 32'(v.we));
                chk("issue_rreq", 32'(sram_rreq), 32'(!v.we));
                if (v.we) begin
                    chk("issue_waddr", 32'(sram_waddr), 32'(v.addr));
                    chk("issue_wdata", 32'(sram_wdata), 32'(v.wdata));
                end else begin
                    chk("issue_raddr", 32'(sram_raddr), 32'(v.addr));
                end
            end else begin
                chk("req_pulse_one_cycle", 32'(sram_wreq | sram_rreq), 0);
            end
            chk("a_ack_timing", 32'(a_ack), (n == ACC + 2 && !v.use_b) ? 1 : 0);
            chk("b_ack_timing", 32'(b_ack), (n == ACC + 2 && v.use_b) ? 1 : 0);
            chk("busy", 32'(busy), (n == ACC + 3) ? 0 : 1);
            if (n == ACC + 2) begin
                if (!v.we) begin
                    if (v.use_b) exp_b_rdata = v.rdval;
                    else         exp_a_rdata = v.rdval;
                end
                chk("rvalid", 32'(v.use_b ? b_rvalid : a_rvalid), 32'(!v.we));
                chk("other_rvalid", 32'(v.use_b ? a_rvalid : b_rvalid), 0);
                a_req = 1'b0;
                b_req = 1'b0;
            end
            if (n >= ACC + 2) begin
                chk("a_rdata", 32'(a_rdata), 32'(exp_a_rdata));
                chk("b_rdata", 32'(b_rdata), 32'(exp_b_rdata));
            end
            sram_rdata = (n == ACC + 1) ? v.rdval : ~v.rdval;
        end
    endtask

    initial begin
        int            pulses;
        int            p_cyc[2];
        logic [AW-1:0] p_addr[2];
        int            order[6];
        int            nack;
        logic          a_re, b_re;
        int            acks;
        vec_t          v;

        a_req = 0; a_we = 0; a_addr = '0; a_wdata = '0;
        b_req = 0; b_we = 0; b_addr = '0; b_wdata = '0;
        sram_rdata = '0;
        s_a_req = 0; s_a_we = 0; s_a_addr = '0; s_a_wdata = '0;
        s_b_req = 0; s_b_we = 0; s_b_addr = '0; s_b_wdata = '0;
        s_sram_rdata = '0;

        vecs[0] = '{1'b0, 1'b1, 15'h1234, 8'h5A, 8'h00};
        vecs[1] = '{1'b1, 1'b0, 15'h0007, 8'h00, 8'hC3};
        vecs[2] = '{1'b0, 1'b0, 15'h7FFF, 8'h00, 8'hA5};
        vecs[3] = '{1'b1, 1'b1, 15'h0000, 8'hFF, 8'h00};
        vecs[4] = '{1'b0, 1'b1, 15'h4000, 8'h01, 8'h00};
        vecs[5] = '{1'b0, 1'b0, 15'h2AAA, 8'h00, 8'h96};

        // Reset values
        repeat (2) @(posedge clk); #1;
        chk("rst_busy", 32'(busy), 0);
        chk("rst_wreq", 32'(sram_wreq), 0);
        chk("rst_rreq", 32'(sram_rreq), 0);
        chk("rst_acks", 32'({a_ack, b_ack, a_rvalid, b_rvalid}), 0);
        chk("rst_rdata", 32'({a_rdata, b_rdata}), 0);
        chk("rst_waddr", 32'(sram_waddr), 0);
        chk("rst_raddr", 32'(sram_raddr), 0);
        chk("rst_wdata", 32'(sram_wdata), 0);
        do_reset();

        // Table of single-port transactions
        for (int i = 0; i < 6; i++) run_txn(vecs[i]);

        // First tie after reset: A first, B issued ACC+3 cycles later
        do_reset();
        chk("reset_clears_a_rdata", 32'(a_rdata), 0);
        a_we = 1; a_addr = 15'h0011; a_wdata = 8'h11;
        b_we = 1; b_addr = 15'h0022; b_wdata = 8'h22;
        a_req = 1; b_req = 1;
        pulses = 0; p_cyc[0] = 0; p_cyc[1] = 0; p_addr[0] = '0; p_addr[1] = '0;
        for (int n = 1; n <= 20; n++) begin
            @(posedge clk); #1;
            if (sram_wreq) begin
                if (pulses < 2) begin
                    p_cyc[pulses]  = n;
                    p_addr[pulses] = sram_waddr;
                end
                pulses++;
            end
            if (a_ack) a_req = 0;
            if (b_ack) b_req = 0;
        end
        chk("tie_pulse_count", 32'(pulses), 2);
        chk("tie_first_cycle", 32'(p_cyc[0]), 1);
        chk("tie_first_addr", 32'(p_addr[0]), 32'h11);
        chk("tie_second_cycle", 32'(p_cyc[1]), 1 + ACC + 3);
        chk("tie_second_addr", 32'(p_addr[1]), 32'h22);

        // Continuous contention: strict alternation
        a_req = 1; b_req = 1; nack = 0; a_re = 0; b_re = 0;
        for (int i = 0; i < 6; i++) order[i] = -1;
        for (int n = 0; n < 200 && nack < 6; n++) begin
            @(posedge clk); #1;
            if (a_re) begin a_req = 1; a_re = 0; end
            if (b_re) begin b_req = 1; b_re = 0; end
            if (a_ack) begin
                if (nack < 6) order[nack] = 0;
                nack++; a_req = 0; a_re = 1;
            end
            if (b_ack) begin
                if (nack < 6) order[nack] = 1;
                nack++; b_req = 0; b_re = 1;
            end
        end
        a_req = 0; b_req = 0;
        chk("contention_ack_count", 32'(nack), 6);
        for (int i = 0; i < 6; i++) chk($sformatf("contention_order_%0d", i), 32'(order[i]), 32'(i % 2));
        repeat (ACC + 4) @(posedge clk); #1;

        // Reset mid-access: abort, no ack, last_grant back to B
        v = '{1'b0, 1'b1, 15'h0100, 8'h77, 8'h00};
        run_txn(v);
        a_we = 0; a_addr = 15'h0200; a_req = 1;
        repeat (3) @(posedge clk); #1;
        chk("pre_reset_busy", 32'(busy), 1);
        rst = 0; a_req = 0;
        #1;
        chk("midrst_busy", 32'(busy), 0);
        chk("midrst_reqs", 32'({sram_wreq, sram_rreq}), 0);
        chk("midrst_acks", 32'({a_ack, b_ack, a_rvalid, b_rvalid}), 0);
        chk("midrst_addr", 32'(sram_raddr), 0);
        chk("midrst_wdata", 32'(sram_wdata), 0);
        @(negedge clk); rst = 1;
        acks = 0;
        for (int n = 0; n < 10; n++) begin
            @(posedge clk); #1;
            if (a_ack || b_ack || busy) acks++;
        end
        chk("no_ack_after_reset", 32'(acks), 0);
        a_we = 1; a_addr = 15'h0031; b_we = 1; b_addr = 15'h0032;
        a_req = 1; b_req = 1;
        pulses = 0; p_addr[0] = '0;
        for (int n = 1; n <= 20; n++) begin
            @(posedge clk); #1;
            if (sram_wreq && pulses == 0) begin
                p_addr[0] = sram_waddr;
                pulses = 1;
            end
            if (a_ack) a_req = 0;
            if (b_ack) b_req = 0;
        end
        chk("post_reset_tie_addr", 32'(p_addr[0]), 32'h31);

        // Single-cycle access on the ACC_CYCLES=1 instance
        s_sram_rdata = 8'hFF;
        s_b_we = 0; s_b_addr = 15'h0042; s_b_req = 1;
        for (int n = 1; n <= 4; n++) begin
            @(posedge clk); #1;
            if (n == 1) begin
                chk("acc1_rreq", 32'(s_sram_rreq), 1);
                chk("acc1_raddr", 32'(s_sram_raddr), 32'h42);
            end
            if (n == 2) begin
                chk("acc1_rreq_pulse", 32'(s_sram_rreq), 0);
                chk("acc1_no_early_ack", 32'(s_b_ack), 0);
                chk("acc1_wait_busy", 32'(s_busy), 1);
            end
            if (n == 3) begin
                chk("acc1_ack", 32'(s_b_ack), 1);
                chk("acc1_rvalid", 32'(s_b_rvalid), 1);
                chk("acc1_rdata", 32'(s_b_rdata), 32'h3C);
                s_b_req = 0;
            end
            if (n == 4) begin
                chk("acc1_idle", 32'(s_busy), 0);
                chk("acc1_ack_pulse", 32'(s_b_ack), 0);
                chk("acc1_rdata_held", 32'(s_b_rdata), 32'h3C);
            end
            s_sram_rdata = (n == 2) ? 8'h3C : 8'hC3;
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
